matrix_display_tx: RTL and testbench
====================================

// Module: matrix_display_tx
// PURPOSE
//  Reads a committed matrix from BRAM and streams it over UART as ASCII decimal text.
//  Output is one row per line: elements separated by a single space, each row ending in CR LF.
//  Output counterpart of the matrix input parser; driven by the display/calc mode controller
//  with slot geometry taken from the matrix manager.
// PARAMETERS
//  ELEMENT_WIDTH  `ELEMENT_WIDTH (8)     unsigned element width; printed as 1..3 decimal digits
//  ADDR_WIDTH     `BRAM_ADDR_WIDTH       BRAM address width
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    reset, asynchronous, active-low
//  mode_active    in   1    low = abort and hold in IDLE
//  start          in   1    1-cycle pulse; latches disp_m/disp_n/disp_addr; ignored unless IDLE
//  disp_m         in   4    row count
//  disp_n         in   4    column count
//  disp_addr      in   AW   base address; row-major layout
//  config_max_dim in   4    maximum legal dimension
//  mem_rd_en      out  1    BRAM read strobe; data valid exactly 1 cycle later
//  mem_rd_addr    out  AW   BRAM read address
//  mem_rd_data    in   EW   BRAM read data
//  tx_data        out  8    UART byte
//  tx_start       out  1    1-cycle send pulse
//  tx_busy        in   1    UART transmitter busy
//  busy           out  1    high from accepted start until done
//  done           out  1    1-cycle pulse at end of a print or an error
//  error_code     out  4    `ERR_NONE / `ERR_DIM_RANGE; holds until next start
// BEHAVIOUR
//  Reset values: every output is 0; error_code = `ERR_NONE; state = IDLE.
//  States: IDLE -> CHECK -> RD_REQ -> RD_WAIT -> CONV -> SEND_DIG -> (SEND_SP | SEND_CR -> SEND_LF)
//          -> RD_REQ or FINISH -> IDLE.  ERROR -> FINISH.
//  CHECK: if m == 0, n == 0, m > config_max_dim, or n > config_max_dim:
//         set error_code = `ERR_DIM_RANGE, go to ERROR; no BRAM reads and no bytes are sent.
//  Addressing: offset counter starts at 0 and increments by 1 per element; mem_rd_addr = disp_addr + offset.
//         Column and row counters are used; no multiplier. Address wraps modulo 2^AW.
//  RD_REQ: assert mem_rd_en for 1 cycle. RD_WAIT: capture mem_rd_data on the next cycle.
//  CONV: extract hundreds, tens and ones by iterative subtraction (no divider); at most 12 cycles.
//         Leading zeros are suppressed; the value 0 prints as "0".
//  TX handshake:
//    - tx_start is pulsed only when tx_busy == 0.
//    - After each pulse, wait 1 cycle, then wait for tx_busy == 0 before the next byte.
//    - Never 2 pulses in consecutive cycles. Byte order is strictly preserved.
//  Separator: a space (0x20) is sent after each column except the last; CR (0x0D) then LF (0x0A)
//         follow the last column of each row.
//  FINISH: done = 1 for 1 cycle; busy drops in the same cycle.
//  mode_active = 0 at any point: go to IDLE next cycle.
//    - tx_start and mem_rd_en are forced 0; busy drops to 0; done is not pulsed.
//    - A byte already handed to the UART completes on its own.
//  start while busy: ignored. Reset mid-print: all outputs return to reset values immediately.
// CONFIGURATION
//  MATRIX_DISP_HEADER_EN defined:
//    - Before the data, send a header line: m digit, 'x', n digit, CR, LF (e.g. "2x3\r\n").
//    - The header is suppressed on a dimension error.
//  MATRIX_DISP_HEADER_EN undefined: output starts directly with the first element.
// STRUCTURE
//  matrix_pkg.vh: `ELEMENT_WIDTH, `BRAM_ADDR_WIDTH, `ERR_NONE, `ERR_DIM_RANGE,
//    ASCII constants (`ASCII_SP, `ASCII_CR, `ASCII_LF, `ASCII_0).
//  Sub-module bin2dec_seq: sequential EW-bit to 3-digit BCD converter.
//    Interface: start/value in; done/digit count/3 digits out.
//    Shared with other print paths; the state machine and counters stay in the top module.
// TESTING
//  1. 2x3 matrix [1 2 3; 4 5 6] at addr 0x010
//     -> bytes "1 2 3\r\n4 5 6\r\n"; reads at 0x010..0x015 in order; 1 done pulse.
//  2. 1x3 matrix [0, 10, 255] -> "0 10 255\r\n"; no leading zeros are sent.
//  3. disp_m = 0, then disp_n = 6 with config_max_dim = 5
//     -> error_code = `ERR_DIM_RANGE; done pulses; 0 reads; 0 tx_start pulses.
//  4. Hold tx_busy high for 200 cycles at random points during a 3x3 print
//     -> no tx_start while busy; output byte stream is identical to the unstalled run.
//  5. Drop mode_active in the middle of row 2 of a 3x3 print
//     -> next cycle IDLE, busy = 0, no further tx_start or mem_rd_en, no done pulse;
//        a following start prints the full matrix correctly.
//  6. With MATRIX_DISP_HEADER_EN, 2x2 matrix [7 8; 9 1] -> "2x2\r\n7 8\r\n9 1\r\n".

Source files
------------

// File: rtl/matrix_display_tx_pkg.sv
// Shared types and constants for the matrix display transmitter and its
// decimal converter. ASCII codes, error codes and default widths live here.
package matrix_display_tx_pkg;

    localparam int DEF_ELEMENT_WIDTH   = 8;
    localparam int DEF_BRAM_ADDR_WIDTH = 10;

    localparam logic [3:0] ERR_NONE      = 4'h0;
    localparam logic [3:0] ERR_DIM_RANGE = 4'h1;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_HDR,
        S_RD_REQ,
        S_RD_WAIT,
        S_CONV,
        S_SEND_DIG,
        S_SEND_SP,
        S_SEND_CR,
        S_SEND_LF,
        S_ERROR,
        S_FINISH
    } disp_state_t;

    typedef enum logic [1:0] {
        B2D_IDLE,
        B2D_HUND,
        B2D_TENS
    } b2d_state_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/matrix_display_tx_bin2dec_seq.sv
// Sequential binary to 3-digit BCD converter using repeated subtraction.
// A new start always restarts the conversion, even if one is in progress.
module bin2dec_seq
    import matrix_display_tx_pkg::*;
#(
    parameter int EW = DEF_ELEMENT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [EW-1:0] i_value,
    output logic          o_done,
    output logic [1:0]    o_ndig,
    output logic [3:0]    o_hund,
    output logic [3:0]    o_tens,
    output logic [3:0]    o_ones
);

    localparam logic [EW-1:0] C100 = EW'(100);
    localparam logic [EW-1:0] C10  = EW'(10);

    b2d_state_t    r_state;
    logic [EW-1:0] r_rem;
    logic [3:0]    r_hund;
    logic [3:0]    r_tens;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= B2D_IDLE;
            r_rem   <= '0;
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            o_done  <= 1'b0;
            o_ndig  <= 2'd0;
            o_hund  <= 4'd0;
            o_tens  <= 4'd0;
            o_ones  <= 4'd0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_rem   <= i_value;
                r_hund  <= 4'd0;
                r_tens  <= 4'd0;
                r_state <= B2D_HUND;
            end else begin
                case (r_state)
                    B2D_HUND: begin
                        if (r_rem >= C100) begin
                            r_rem  <= r_rem - C100;
                            r_hund <= r_hund + 4'd1;
                        end else begin
                            r_state <= B2D_TENS;
                        end
                    end
                    B2D_TENS: begin
                        if (r_rem >= C10) begin
                            r_rem  <= r_rem - C10;
                            r_tens <= r_tens + 4'd1;
                        end else begin
                            o_hund  <= r_hund;
                            o_tens  <= r_tens;
                            o_ones  <= r_rem[3:0];
                            o_ndig  <= (r_hund != 4'd0) ? 2'd3 :
                                       (r_tens != 4'd0) ? 2'd2 : 2'd1;
                            o_done  <= 1'b1;
                            r_state <= B2D_IDLE;
                        end
                    end
                    default: r_state <= B2D_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/matrix_display_tx.sv
// Streams a BRAM matrix over a UART as decimal text, one row per line.
// Optional "MxN\r\n" header line when MATRIX_DISP_HEADER_EN is defined.
// IDLE idle | CHECK dims | HDR header | RD_REQ/RD_WAIT read | CONV decimal
// SEND_DIG digits | SEND_SP space | SEND_CR/LF eol | ERROR bad dims | FINISH done
module matrix_display_tx
    import matrix_display_tx_pkg::*;
#(
    parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = DEF_BRAM_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_mode_active,
    input  logic                     i_start,
    input  logic [3:0]               i_disp_m,
    input  logic [3:0]               i_disp_n,
    input  logic [ADDR_WIDTH-1:0]    i_disp_addr,
    input  logic [3:0]               i_config_max_dim,
    output logic                     o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    o_mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] i_mem_rd_data,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_start,
    input  logic                     i_tx_busy,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [3:0]               o_error_code
);

    disp_state_t           r_state;
    logic [3:0]            r_m;
    logic [3:0]            r_n;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_offset;
    logic [3:0]            r_row;
    logic [3:0]            r_col;
    logic [1:0]            r_dig_idx;
    logic                  r_tx_hold;
    logic                  r_conv_run;
`ifdef MATRIX_DISP_HEADER_EN
    logic [2:0]            r_hdr_idx;
    logic                  w_hdr_skip;
`endif

    logic       w_can_send;
    logic [7:0] w_tx_byte;
    logic       w_last_col;
    logic       w_last_row;
    logic       w_dim_bad;
    logic       w_b2d_start;
    logic       w_b2d_done;
    logic [1:0] w_ndig;
    logic [3:0] w_hund;
    logic [3:0] w_tens;
    logic [3:0] w_ones;

    // r_tx_hold covers the cycle after each pulse, before the UART raises busy
    assign w_can_send  = !r_tx_hold && !i_tx_busy;
    assign w_last_col  = (r_col == r_n - 4'd1);
    assign w_last_row  = (r_row == r_m - 4'd1);
    assign w_dim_bad   = (r_m == 4'd0) || (r_n == 4'd0) ||
                         (r_m > i_config_max_dim) || (r_n > i_config_max_dim);
    assign w_b2d_start = i_mode_active && (r_state == S_CONV) && !r_conv_run;

    bin2dec_seq #(
        .EW (ELEMENT_WIDTH)
    ) u_bin2dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_b2d_start),
        .i_value (i_mem_rd_data),
        .o_done  (w_b2d_done),
        .o_ndig  (w_ndig),
        .o_hund  (w_hund),
        .o_tens  (w_tens),
        .o_ones  (w_ones)
    );

`ifdef MATRIX_DISP_HEADER_EN
    function automatic logic [3:0] dim_ones(input logic [3:0] d);
        return (d >= 4'd10) ? d - 4'd10 : d;
    endfunction

    // Tens slots (0 and 3) are skipped for single-digit dimensions
    assign w_hdr_skip = ((r_hdr_idx == 3'd0) && (r_m < 4'd10)) ||
                        ((r_hdr_idx == 3'd3) && (r_n < 4'd10));
`endif

    always_comb begin
        w_tx_byte = ASCII_SP;
        case (r_state)
            S_SEND_DIG: begin
                case (r_dig_idx)
                    2'd2:    w_tx_byte = digit_ascii(w_hund);
                    2'd1:    w_tx_byte = digit_ascii(w_tens);
                    default: w_tx_byte = digit_ascii(w_ones);
                endcase
            end
            S_SEND_CR: w_tx_byte = ASCII_CR;
            S_SEND_LF: w_tx_byte = ASCII_LF;
`ifdef MATRIX_DISP_HEADER_EN
            S_HDR: begin
                case (r_hdr_idx)
                    3'd0, 3'd3: w_tx_byte = digit_ascii(4'd1);
                    3'd1:       w_tx_byte = digit_ascii(dim_ones(r_m));
                    3'd2:       w_tx_byte = ASCII_X;
                    3'd4:       w_tx_byte = digit_ascii(dim_ones(r_n));
                    3'd5:       w_tx_byte = ASCII_CR;
                    default:    w_tx_byte = ASCII_LF;
                endcase
            end
`endif
            default: w_tx_byte = ASCII_SP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_m           <= 4'd0;
            r_n           <= 4'd0;
            r_base        <= '0;
            r_offset      <= '0;
            r_row         <= 4'd0;
            r_col         <= 4'd0;
            r_dig_idx     <= 2'd0;
            r_tx_hold     <= 1'b0;
            r_conv_run    <= 1'b0;
`ifdef MATRIX_DISP_HEADER_EN
            r_hdr_idx     <= 3'd0;
`endif
            o_mem_rd_en   <= 1'b0;
            o_mem_rd_addr <= '0;
            o_tx_data     <= 8'd0;
            o_tx_start    <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error_code  <= ERR_NONE;
        end else if (!i_mode_active) begin
            r_state     <= S_IDLE;
            r_tx_hold   <= 1'b0;
            r_conv_run  <= 1'b0;
            o_mem_rd_en <= 1'b0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_mem_rd_en <= 1'b0;
            o_tx_start  <= 1'b0;
            o_done      <= 1'b0;
            r_tx_hold   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_m          <= i_disp_m;
                        r_n          <= i_disp_n;
                        r_base       <= i_disp_addr;
                        o_busy       <= 1'b1;
                        o_error_code <= ERR_NONE;
                        r_state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_offset <= '0;
                    r_row    <= 4'd0;
                    r_col    <= 4'd0;
`ifdef MATRIX_DISP_HEADER_EN
                    r_hdr_idx <= 3'd0;
`endif
                    if (w_dim_bad) begin
                        o_error_code <= ERR_DIM_RANGE;
                        r_state      <= S_ERROR;
                    end else begin
`ifdef MATRIX_DISP_HEADER_EN
                        r_state <= S_HDR;
`else
                        r_state <= S_RD_REQ;
`endif
                    end
                end
`ifdef MATRIX_DISP_HEADER_EN
                S_HDR: begin
                    if (w_hdr_skip) begin
                        r_hdr_idx <= r_hdr_idx + 3'd1;
                    end else if (w_can_send) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= w_tx_byte;
                        r_tx_hold  <= 1'b1;
                        if (r_hdr_idx == 3'd6) r_state <= S_RD_REQ;
                        else                   r_hdr_idx <= r_hdr_idx + 3'd1;
                    end
                end
`endif
                S_RD_REQ: begin
                    o_mem_rd_en   <= 1'b1;
                    o_mem_rd_addr <= r_base + r_offset;
                    r_state       <= S_RD_WAIT;
                end
                S_RD_WAIT: r_state <= S_CONV;
                S_CONV: begin
                    if (!r_conv_run) begin
                        r_conv_run <= 1'b1;
                    end else if (w_b2d_done) begin
                        r_conv_run <= 1'b0;
                        r_dig_idx  <= w_ndig - 2'd1;
                        r_state    <= S_SEND_DIG;
                    end
                end
                S_SEND_DIG: begin
                    if (w_can_send) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= w_tx_byte;
                        r_tx_hold  <= 1'b1;
                        if (r_dig_idx == 2'd0) r_state <= w_last_col ? S_SEND_CR : S_SEND_SP;
                        else                   r_dig_idx <= r_dig_idx - 2'd1;
                    end
                end
                S_SEND_SP: begin
                    if (w_can_send) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= w_tx_byte;
                        r_tx_hold  <= 1'b1;
                        r_col      <= r_col + 4'd1;
                        r_offset   <= r_offset + ADDR_WIDTH'(1);
                        r_state    <= S_RD_REQ;
                    end
                end
                S_SEND_CR: begin
                    if (w_can_send) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= w_tx_byte;
                        r_tx_hold  <= 1'b1;
                        r_state    <= S_SEND_LF;
                    end
                end
                S_SEND_LF: begin
                    if (w_can_send) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= w_tx_byte;
                        r_tx_hold  <= 1'b1;
                        if (w_last_row) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_row    <= r_row + 4'd1;
                            r_col    <= 4'd0;
                            r_offset <= r_offset + ADDR_WIDTH'(1);
                            r_state  <= S_RD_REQ;
                        end
                    end
                end
                S_ERROR: r_state <= S_FINISH;
                S_FINISH: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_display_tx.sv
// Scoreboard bench for matrix_display_tx: a text-formatting reference model
// queues expected bytes/addresses; negedge monitors pop and compare.
module tb_matrix_display_tx;
    import matrix_display_tx_pkg::*;

    localparam int AW  = DEF_BRAM_ADDR_WIDTH;
    localparam int EW  = DEF_ELEMENT_WIDTH;
    localparam int LIM = 20000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode_active = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    disp_m = 4'd0;
    logic [3:0]    disp_n = 4'd0;
    logic [AW-1:0] disp_addr = '0;
    logic [3:0]    cfg_max = 4'd5;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [EW-1:0] mem_rd_data = '0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          busy;
    logic          done;
    logic [3:0]    error_code;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] mem [0:(1<<AW)-1];
    logic [7:0]    exp_tx[$];
    logic [AW-1:0] exp_rd[$];
    logic [7:0]    got_tx[$];
    logic [7:0]    ref_stream[$];
    int done_cnt = 0;
    int tx_cnt   = 0;
    int rd_cnt   = 0;
    int uart_cnt = 0;
    logic stall = 1'b0;
    logic busy_seen = 1'b0;
    logic prev_tx_start = 1'b0;

    always #5 clk = ~clk;

    assign tx_busy = (uart_cnt != 0) || stall;

    matrix_display_tx dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_mode_active    (mode_active),
        .i_start          (start),
        .i_disp_m         (disp_m),
        .i_disp_n         (disp_n),
        .i_disp_addr      (disp_addr),
        .i_config_max_dim (cfg_max),
        .o_mem_rd_en      (mem_rd_en),
        .o_mem_rd_addr    (mem_rd_addr),
        .i_mem_rd_data    (mem_rd_data),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .i_tx_busy        (tx_busy),
        .o_busy           (busy),
        .o_done           (done),
        .o_error_code     (error_code)
    );

    // BRAM with one-cycle read latency and a UART with a random byte time
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        busy_seen <= tx_busy;
        if (tx_start)          uart_cnt <= $urandom_range(2, 8);
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start) begin
            tx_cnt++;
            got_tx.push_back(tx_data);
            check("tx_while_busy", busy_seen, 0);
            check("tx_back_to_back", prev_tx_start, 0);
            if (exp_tx.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_unexpected: got byte %0d expected none at %0t", tx_data, $time);
            end else begin
                check("tx_byte", tx_data, exp_tx.pop_front());
            end
        end
        prev_tx_start = tx_start;
        if (mem_rd_en) begin
            rd_cnt++;
            if (exp_rd.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got addr %0d expected none at %0t", mem_rd_addr, $time);
            end else begin
                check("rd_addr", mem_rd_addr, exp_rd.pop_front());
            end
        end
        if (done) done_cnt++;
    end

    // Reference model: format the matrix as text with plain string arithmetic
    task automatic push_expect(input int m, input int n, input int base);
        string s;
`ifdef MATRIX_DISP_HEADER_EN
        s = $sformatf("%0dx%0d\r\n", m, n);
        for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
`endif
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                int a;
                a = (base + r * n + c) % (1 << AW);
                exp_rd.push_back(a[AW-1:0]);
                s = $sformatf("%0d", mem[a]);
                for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
                if (c == n - 1) begin
                    exp_tx.push_back(8'h0D);
                    exp_tx.push_back(8'h0A);
                end else begin
                    exp_tx.push_back(8'h20);
                end
            end
        end
    endtask

    task automatic fill_random(input int m, input int n, input int base);
        int specials [6];
        specials = '{0, 9, 10, 99, 100, 255};
        for (int i = 0; i < m * n; i++) begin
            if ($urandom_range(0, 2) == 0) mem[(base + i) % (1 << AW)] = EW'(specials[$urandom_range(0, 5)]);
            else                           mem[(base + i) % (1 << AW)] = EW'($urandom_range(0, 255));
        end
    endtask

    task automatic launch(input int m, input int n, input int base, input int maxd);
        @(posedge clk); #1;
        disp_m = 4'(m); disp_n = 4'(n); disp_addr = AW'(base); cfg_max = 4'(maxd);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_print(input int m, input int n, input int base, input int maxd, input bit err);
        int d0, t0, r0, cyc;
        d0 = done_cnt; t0 = tx_cnt; r0 = rd_cnt; cyc = 0;
        if (!err) push_expect(m, n, base);
        launch(m, n, base, maxd);
        while (done_cnt == d0 && cyc < LIM) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (cyc >= LIM) begin
            total++; bad++;
            $display("FAIL done_timeout: waited %0d cycles expected done", cyc);
        end
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("busy_after_done", busy, 0);
        check("error_code", error_code, err ? 1 : 0);
        check("tx_left", exp_tx.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        if (err) begin
            check("err_tx_count", tx_cnt - t0, 0);
            check("err_rd_count", rd_cnt - r0, 0);
        end
    endtask

    initial begin
        #12;
        check("reset_outputs", {tx_start, mem_rd_en, busy, done, tx_data, mem_rd_addr, error_code}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 6; i++) mem[16 + i] = EW'(i + 1);
        run_print(2, 3, 16, 5, 0);

        mem[100] = 0; mem[101] = 10; mem[102] = 255;
        run_print(1, 3, 100, 5, 0);

        run_print(0, 3, 200, 5, 1);
        run_print(2, 6, 200, 5, 1);
        fill_random(5, 1, 300);
        run_print(5, 1, 300, 5, 0);

        for (int it = 0; it < 8; it++) begin
            int m, n, base, maxd;
            maxd = $urandom_range(1, 15);
            m = $urandom_range(1, (maxd < 6) ? maxd : 6);
            n = $urandom_range(1, (maxd < 6) ? maxd : 6);
            base = (it == 3) ? 1020 : $urandom_range(0, (1 << AW) - 1);
            fill_random(m, n, base);
            run_print(m, n, base, maxd, 0);
        end
        fill_random(1, 15, 500);
        run_print(1, 15, 500, 15, 0);

        // 3x3 across the address wrap, unstalled then with long busy stalls
        fill_random(3, 3, 1020);
        got_tx.delete();
        run_print(3, 3, 1020, 5, 0);
        ref_stream = got_tx;
        got_tx.delete();
        fork
            run_print(3, 3, 1020, 5, 0);
            begin
                repeat (2) begin
                    repeat ($urandom_range(5, 40)) @(posedge clk);
                    #1 stall = 1'b1;
                    repeat (200) @(posedge clk);
                    #1 stall = 1'b0;
                end
            end
        join
        check("stall_stream_len", got_tx.size(), ref_stream.size());
        for (int i = 0; i < got_tx.size() && i < ref_stream.size(); i++)
            check("stall_stream_byte", got_tx[i], ref_stream[i]);

        // abort in the middle of row 2
        begin
            int r0, d0, t0, cyc;
            fill_random(3, 3, 600);
            push_expect(3, 3, 600);
            r0 = rd_cnt; cyc = 0;
            launch(3, 3, 600, 5);
            while (rd_cnt - r0 < 5 && cyc < LIM) begin
                @(posedge clk);
                cyc++;
            end
            check("abort_reached_row2", rd_cnt - r0, 5);
            @(posedge clk); #1;
            mode_active = 1'b0;
            d0 = done_cnt;
            @(posedge clk); #1;
            check("abort_busy", busy, 0);
            check("abort_tx_start", tx_start, 0);
            check("abort_rd_en", mem_rd_en, 0);
            exp_tx.delete();
            exp_rd.delete();
            t0 = tx_cnt;
            repeat (60) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_no_tx", tx_cnt - t0, 0);
            mode_active = 1'b1;
            run_print(3, 3, 600, 5, 0);
        end

        // asynchronous reset in the middle of a print
        begin
            int t0, cyc;
            fill_random(2, 4, 700);
            push_expect(2, 4, 700);
            t0 = tx_cnt; cyc = 0;
            launch(2, 4, 700, 5);
            while (tx_cnt - t0 < 3 && cyc < LIM) begin
                @(posedge clk);
                cyc++;
            end
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            check("midreset_outputs", {tx_start, mem_rd_en, busy, done, tx_data, mem_rd_addr, error_code}, 0);
            exp_tx.delete();
            exp_rd.delete();
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            run_print(2, 4, 700, 5, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
